dmem_bank_arbiter: RTL
======================

// Module: dmem_bank_arbiter
// PURPOSE
// - Per-bank arbiter between the Mage datapath port and the bank-decoded external (bus) port of the data memory.
// - Sits between the external bank decoder and the N_BANKS SRAM banks; replaces OR-merging of requests during EXEC.
// - Mage has default priority; a bounded-wait counter guarantees external forward progress.
// - Returns read data to the granted requester with 1-cycle latency.
// PARAMETERS
// - N_BANKS    8    number of dmem banks (power of 2)
// - BANK_SIZE  1024 words per bank
// - N_BITS     32   data width
// - MAX_WAIT   4    max consecutive cycles ext may lose to Mage before forced win (1..15)
// PORTS
// - clk_i          in   1                       clock, all state on rising edge
// - rst_n_i        in   1                       reset, synchronous, active-low
// - mage_req_i     in   N_BANKS                 Mage per-bank request
// - mage_we_i      in   N_BANKS                 Mage per-bank write enable
// - mage_addr_i    in   N_BANKS x clog2(BANK_SIZE)  Mage word address per bank
// - mage_wdata_i   in   N_BANKS x N_BITS        Mage write data per bank
// - mage_gnt_o     out  N_BANKS                 Mage grant per bank (combinational)
// - mage_rvalid_o  out  N_BANKS                 response valid, 1 cycle after grant
// - mage_rdata_o   out  N_BANKS x N_BITS        read data; 0 when rvalid=0 or write
// - ext_req_i      in   1                       external request, held until ext_gnt_o
// - ext_we_i       in   1                       external write enable
// - ext_bank_i     in   clog2(N_BANKS)          target bank (from decoder)
// - ext_addr_i     in   clog2(BANK_SIZE)        word address inside bank
// - ext_wdata_i    in   N_BITS                  external write data
// - ext_gnt_o      out  1                       external grant (combinational)
// - ext_rvalid_o   out  1                       response valid, 1 cycle after grant
// - ext_rdata_o    out  N_BITS                  read data; 0 when rvalid=0 or write
// - dmem_req_o/we_o/addr_o/wdata_o  out  per-bank  to banks
// - dmem_rdata_i   in   N_BANKS x N_BITS        bank read data, valid 1 cycle after req
// - perf_conflict_o out 32                      conflict cycles (see CONFIGURATION)
// - perf_forced_o   out 32                      forced ext wins (see CONFIGURATION)
// BEHAVIOUR
// - Bank b conflict: mage_req_i[b] & ext_req_i & ext_bank_i==b. Non-conflicting banks: all requesters granted same cycle.
// - FSM (dmem_arb_state_t): IDLE -> WAIT on conflict where Mage wins; WAIT -> BOOST when wait_cnt==MAX_WAIT-1 and conflict persists;
//   BOOST: ext wins, mage_gnt_o[ext_bank_i]=0, -> IDLE next cycle. Any ext grant -> IDLE, wait_cnt=0.
// - WAIT with ext_req_i dropped or target bank free: grant ext (if req), -> IDLE. Ext request changing before gnt is a protocol error (assertion).
// - wait_cnt 4 bits, saturates at MAX_WAIT-1; never wraps. MAX_WAIT=1: ext forced every second conflicting cycle.
// - Muxing: granted ext drives addr/wdata/we of ext_bank_i; otherwise Mage fields pass through; ungranted banks: req=0, addr=0, wdata=0.
// - Response: registered rsp_owner[b] (MAGE/EXT) and rsp_we[b]; next cycle rvalid to owner; rdata=dmem_rdata_i[b] only for reads.
// - Same-cycle ext grant + Mage grant on different banks: both rvalid next cycle, independent.
// - Reset (rst_n_i=0 at edge): FSM=IDLE, wait_cnt=0, rsp regs cleared, perf counters=0. While rst_n_i=0 all grants, dmem_req_o, rvalids forced 0.
//   Reset mid-request discards in-flight responses (no rvalid after reset).
// CONFIGURATION
// - Macro DMEM_ARB_PERF_EN: defined -> perf_conflict_o counts cycles with a conflict, perf_forced_o counts BOOST cycles; both 32-bit, saturating at 2^32-1.
// - Not defined -> counters not instantiated, ports tied to 32'h0.
// STRUCTURE
// - mage_pkg: dmem_arb_state_t {ARB_IDLE, ARB_WAIT, ARB_BOOST}; rsp_owner_t {OWN_MAGE, OWN_EXT}; DMEM_ARB_MAX_WAIT default constant.
// - Reuse N_BANKS/BANK_SIZE/N_BITS from pea_pkg/mage_pkg. Single module, no sub-module; perf counters in an ifdef block.
// TESTING
// - No conflict: ext read bank 3 addr 0x10, Mage writes bank 0 -> both granted cycle 0; ext_rvalid_o=1 cycle 1 with bank3[0x10].
// - Conflict, MAX_WAIT=4, Mage holds bank 2 every cycle, ext read bank 2 -> ext_gnt_o at cycle 4, mage_gnt_o[2]=0 that cycle only.
// - Mage releases bank 5 at cycle 2 of ext wait -> ext granted cycle 2, wait_cnt=0, FSM IDLE cycle 3.
// - Ext write 0xDEADBEEF bank 7 addr 0x3FF, then read back -> ext_rdata_o=0xDEADBEEF; write rvalid has rdata=0.
// - rst_n_i low one cycle while ext read pending/in flight -> no rvalid after reset, FSM IDLE, grants 0 during reset.
// - With DMEM_ARB_PERF_EN, 10 conflict cycles MAX_WAIT=4 -> perf_conflict_o=10, perf_forced_o=2; without -> both 0.

Source files
------------

// File: rtl/mage_pkg.sv
// Shared constants and types for the Mage data-memory bank arbiter.
// Bank geometry defaults are reused by every dmem-facing block.
package mage_pkg;

    localparam int MAGE_N_BANKS      = 8;
    localparam int MAGE_BANK_SIZE    = 1024;
    localparam int MAGE_N_BITS       = 32;
    localparam int DMEM_ARB_MAX_WAIT = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_BOOST
    } dmem_arb_state_t;

    typedef enum logic {
        OWN_MAGE,
        OWN_EXT
    } rsp_owner_t;

endpackage

// File: rtl/dmem_bank_arbiter.sv
// Per-bank arbiter between the Mage datapath and the external bus port; Mage wins by
// default, bounded wait forces ext through. Optional perf counters: DMEM_ARB_PERF_EN.
module dmem_bank_arbiter
    import mage_pkg::*;
#(
    parameter int N_BANKS   = MAGE_N_BANKS,
    parameter int BANK_SIZE = MAGE_BANK_SIZE,
    parameter int N_BITS    = MAGE_N_BITS,
    parameter int MAX_WAIT  = DMEM_ARB_MAX_WAIT
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic [N_BANKS-1:0]                mage_req_i,
    input  logic [N_BANKS-1:0]                mage_we_i,
    input  logic [N_BANKS*$clog2(BANK_SIZE)-1:0] mage_addr_i,
    input  logic [N_BANKS*N_BITS-1:0]         mage_wdata_i,
    output logic [N_BANKS-1:0]                mage_gnt_o,
    output logic [N_BANKS-1:0]                mage_rvalid_o,
    output logic [N_BANKS*N_BITS-1:0]         mage_rdata_o,
    input  logic                              ext_req_i,
    input  logic                              ext_we_i,
    input  logic [$clog2(N_BANKS)-1:0]        ext_bank_i,
    input  logic [$clog2(BANK_SIZE)-1:0]      ext_addr_i,
    input  logic [N_BITS-1:0]                 ext_wdata_i,
    output logic                              ext_gnt_o,
    output logic                              ext_rvalid_o,
    output logic [N_BITS-1:0]                 ext_rdata_o,
    output logic [N_BANKS-1:0]                dmem_req_o,
    output logic [N_BANKS-1:0]                dmem_we_o,
    output logic [N_BANKS*$clog2(BANK_SIZE)-1:0] dmem_addr_o,
    output logic [N_BANKS*N_BITS-1:0]         dmem_wdata_o,
    input  logic [N_BANKS*N_BITS-1:0]         dmem_rdata_i,
    output logic [31:0]                       perf_conflict_o,
    output logic [31:0]                       perf_forced_o
);

    localparam int AW = $clog2(BANK_SIZE);
    localparam int BW = $clog2(N_BANKS);
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT - 1);

    dmem_arb_state_t    state_q, state_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic [N_BANKS-1:0] ext_hit;
    logic [N_BANKS-1:0] ext_sel;
    logic [N_BANKS-1:0] mage_gnt;
    logic               ext_gnt;
    logic               conflict;
    logic               boost;

    rsp_owner_t         rsp_owner_q [N_BANKS];
    logic [N_BANKS-1:0] rsp_vld_q;
    logic [N_BANKS-1:0] rsp_we_q;

    assign ext_hit  = ext_req_i ? (N_BANKS'(1) << ext_bank_i) : '0;
    assign conflict = |(ext_hit & mage_req_i);
    assign boost    = (state_q == ARB_BOOST);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ARB_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // wait_cnt holds the number of consecutive losses already taken; reaching
    // WAIT_LIM on a further loss means the next cycle belongs to ext.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ARB_IDLE, ARB_WAIT: begin
                if (conflict) begin
                    if (wait_cnt_q >= WAIT_LIM) begin
                        state_d    = ARB_BOOST;
                        wait_cnt_d = WAIT_LIM;
                    end else begin
                        state_d    = ARB_WAIT;
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end else begin
                    state_d    = ARB_IDLE;
                    wait_cnt_d = '0;
                end
            end
            ARB_BOOST: begin
                state_d    = ARB_IDLE;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = ARB_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        ext_gnt  = 1'b0;
        mage_gnt = '0;
        if (rst_n_i) begin
            ext_gnt  = ext_req_i & (~conflict | boost);
            mage_gnt = mage_req_i & ~(boost ? ext_hit : '0);
        end
    end

    assign ext_sel    = ext_gnt ? ext_hit : '0;
    assign ext_gnt_o  = ext_gnt;
    assign mage_gnt_o = mage_gnt;

    always_comb begin
        dmem_req_o   = '0;
        dmem_we_o    = '0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            dmem_req_o[b] = mage_gnt[b] | ext_sel[b];
            if (ext_sel[b]) begin
                dmem_we_o[b]                  = ext_we_i;
                dmem_addr_o[b*AW +: AW]       = ext_addr_i;
                dmem_wdata_o[b*N_BITS +: N_BITS] = ext_wdata_i;
            end else if (mage_gnt[b]) begin
                dmem_we_o[b]                  = mage_we_i[b];
                dmem_addr_o[b*AW +: AW]       = mage_addr_i[b*AW +: AW];
                dmem_wdata_o[b*N_BITS +: N_BITS] = mage_wdata_i[b*N_BITS +: N_BITS];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rsp_vld_q <= '0;
            rsp_we_q  <= '0;
            for (int b = 0; b < N_BANKS; b++) rsp_owner_q[b] <= OWN_MAGE;
        end else begin
            rsp_vld_q <= dmem_req_o;
            rsp_we_q  <= dmem_we_o;
            for (int b = 0; b < N_BANKS; b++)
                rsp_owner_q[b] <= ext_sel[b] ? OWN_EXT : OWN_MAGE;
        end
    end

    // Write responses still raise rvalid but carry zero data.
    always_comb begin
        mage_rvalid_o = '0;
        mage_rdata_o  = '0;
        ext_rvalid_o  = 1'b0;
        ext_rdata_o   = '0;
        if (rst_n_i) begin
            for (int b = 0; b < N_BANKS; b++) begin
                if (rsp_vld_q[b]) begin
                    if (rsp_owner_q[b] == OWN_EXT) begin
                        ext_rvalid_o = 1'b1;
                        ext_rdata_o  = ext_rdata_o |
                            (rsp_we_q[b] ? '0 : dmem_rdata_i[b*N_BITS +: N_BITS]);
                    end else begin
                        mage_rvalid_o[b] = 1'b1;
                        mage_rdata_o[b*N_BITS +: N_BITS] =
                            rsp_we_q[b] ? '0 : dmem_rdata_i[b*N_BITS +: N_BITS];
                    end
                end
            end
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_conflict_q;
    logic [31:0] perf_forced_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            perf_conflict_q <= '0;
            perf_forced_q   <= '0;
        end else begin
            if (conflict && perf_conflict_q != 32'hFFFF_FFFF)
                perf_conflict_q <= perf_conflict_q + 32'd1;
            if (boost && perf_forced_q != 32'hFFFF_FFFF)
                perf_forced_q <= perf_forced_q + 32'd1;
        end
    end

    assign perf_conflict_o = perf_conflict_q;
    assign perf_forced_o   = perf_forced_q;
`else
    assign perf_conflict_o = 32'h0;
    assign perf_forced_o   = 32'h0;
`endif

`ifndef SYNTHESIS
    logic              ext_hold_q;
    logic              ext_we_q;
    logic [BW-1:0]     ext_bank_q;
    logic [AW-1:0]     ext_addr_q;
    logic [N_BITS-1:0] ext_wdata_q;

    // An ungranted ext request must be presented unchanged until granted.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && ext_hold_q)
            assert (ext_req_i && ext_we_i == ext_we_q && ext_bank_i == ext_bank_q &&
                    ext_addr_i == ext_addr_q && ext_wdata_i == ext_wdata_q);
        if (!rst_n_i) ext_hold_q <= 1'b0;
        else          ext_hold_q <= ext_req_i & ~ext_gnt;
        ext_we_q    <= ext_we_i;
        ext_bank_q  <= ext_bank_i;
        ext_addr_q  <= ext_addr_i;
        ext_wdata_q <= ext_wdata_i;
    end
`endif

endmodule
